hazard_ctl: RTL
===============

HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port inst_de  input  32  instruction currently in decode.
REQ-004 SHALL have port pc_sel  input  1  execute-stage redirect (taken branch/jal/jalr).
REQ-005 SHALL have port dmem_ready  input  1  data memory completes access this cycle.
REQ-006 SHALL have port stall_fe  output  1  hold PC and fetch/decode register.
REQ-007 SHALL have port stall_de  output  1  hold decode/execute register.
REQ-008 SHALL have port flush_fe  output  1  load NOP into fetch/decode register.
REQ-009 SHALL have port flush_de  output  1  load NOP into decode/execute register.
REQ-010 SHALL have port freeze  output  1  hold every pipeline register incl. execute/access/writeback.
REQ-011 SHALL have ports fwd_a, fwd_b  output  2 each  execute operand source: 00 regfile, 01 access-stage result, 10 writeback result.

Function
REQ-012 SHALL keep shadow instruction registers ex_q, acc_q, wb_q advancing inst_de->ex_q->acc_q->wb_q each unfrozen cycle.
REQ-013 SHALL classify opcodes: writes rd = all except store(0100011)/branch(1100011); uses rs1 = op, op-imm, load, store, branch, jalr; uses rs2 = op, store, branch.
REQ-014 SHALL treat rd = x0 as never producing a hazard or forward.
REQ-015 SHALL run FSM states RUN and MEM_WAIT; RUN->MEM_WAIT when acc_q is load/store and dmem_ready=0; MEM_WAIT->RUN when dmem_ready=1.
REQ-016 SHALL assert freeze, stall_fe, stall_de combinationally whenever acc_q is load/store and dmem_ready=0; all shadow registers hold.
REQ-017 SHALL, when unfrozen and pc_sel=1, assert flush_fe and flush_de for that cycle; ex_q loads NOP (0x00000013).
REQ-018 SHALL detect load-use when ex_q is load and inst_de uses rs1/rs2 equal to ex_q rd; assert stall_fe and stall_de and flush_de for exactly one cycle; ex_q loads NOP, inst_de held.
REQ-019 SHALL prioritise freeze > pc_sel flush > load-use stall; pc_sel during freeze is acted on in the first unfrozen cycle.
REQ-020 SHALL compute fwd_a/fwd_b from ex_q rs1/rs2: 01 if acc_q writes matching rd and is not load, else 10 if wb_q writes matching rd, else 00; access priority over writeback.
REQ-021 SHALL drive fwd_a/fwd_b combinationally with zero latency; stall/flush outputs likewise combinational from registered state and inputs.

Reset
REQ-022 SHALL, on rst=1, immediately set ex_q/acc_q/wb_q to NOP, FSM to RUN, all outputs 0.
REQ-023 SHALL abandon a pending MEM_WAIT or load-use stall on reset mid-operation with no residual stall after release.

Configuration
REQ-024 SHALL compile forwarding only when HAZARD_FWD_EN is defined.
REQ-025 SHALL, without HAZARD_FWD_EN, tie fwd_a/fwd_b to 00 and assert stall_fe, stall_de, flush_de while any of ex_q/acc_q/wb_q writes an rd used by inst_de.

Structure
REQ-026 SHALL place opcode constants, NOP encoding, fwd select encodings and FSM state typedef in shared package rv32_ctl_pkg.
REQ-027 SHALL use sub-module hazard_dec (instruction -> rd, rs1, rs2, writes_rd, uses_rs1, uses_rs2, is_load, is_mem), instantiated per stage.

Verification
REQ-028 SHALL test: add x5,x1,x2 then add x6,x5,x3 -> second in execute gives fwd_a=01; one intervening NOP -> fwd_a=10.
REQ-029 SHALL test: lw x7,0(x1) then add x8,x7,x7 -> one cycle stall_fe=stall_de=flush_de=1, then fwd_a=fwd_b=10.
REQ-030 SHALL test: beq taken (pc_sel=1) -> flush_fe=flush_de=1 one cycle, ex_q becomes 0x00000013.
REQ-031 SHALL test: sw in access, dmem_ready low 3 cycles -> freeze=1 exactly 3 cycles, FSM MEM_WAIT, shadow registers unchanged.
REQ-032 SHALL test: load-use coincident with pc_sel=1 -> flush only, no stall; writes to x0 -> fwd 00, no stall.
REQ-033 SHALL test: rst asserted during MEM_WAIT -> all outputs 0 immediately, RUN after release; without HAZARD_FWD_EN, add-add dependency -> 3 stall cycles.

Source files
------------

// File: rtl/rv32_ctl_pkg.sv
// Shared definitions for the RV32 pipeline hazard controller.
// Contents: opcode constants, NOP encoding, forwarding-select encodings,
// controller FSM state type, per-stage decode record and the register
// match / forwarding-select helpers used by hazard_ctl.
package rv32_ctl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ACC = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } ctl_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       writes_rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_load;
        logic       is_mem;
    } dec_t;

    // True when a consumer source register is produced by an older stage.
    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic uses, input logic [4:0] rs,
                                       input logic writes, input logic [4:0] rd);
        return uses && writes && (rd != 5'd0) && (rs == rd);
    endfunction

    // Operand source for execute: the access stage wins over writeback since it
    // holds the younger value; a load in access has no data yet.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] rs,
                                           input dec_t acc, input dec_t wb);
        logic [1:0] sel;
        if (reg_match(uses, rs, acc.writes_rd & ~acc.is_load, acc.rd)) begin
            sel = FWD_ACC;
        end else if (reg_match(uses, rs, wb.writes_rd, wb.rd)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_dec.sv
// Per-stage instruction classifier for hazard detection.
// Ports:
//   inst       in  32  instruction word held by a pipeline stage
//   rd/rs1/rs2 out  5  register fields
//   writes_rd  out  1  instruction writes a destination register
//   uses_rs1   out  1  instruction reads rs1
//   uses_rs2   out  1  instruction reads rs2
//   is_load    out  1  load opcode
//   is_mem     out  1  load or store opcode
module hazard_dec
    import rv32_ctl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        writes_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_load,
    output logic        is_mem
);

    logic [6:0] opcode_s;

    assign opcode_s = inst[6:0];
    assign rd       = inst[11:7];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];

    // Opcode classification; anything not listed writes rd and reads nothing.
    always_comb begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_load   = 1'b0;
        is_mem    = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: begin
                uses_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                is_load  = 1'b1;
                is_mem   = 1'b1;
            end
            OPC_STORE: begin
                writes_rd = 1'b0;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                is_mem    = 1'b1;
            end
            OPC_BRANCH: begin
                writes_rd = 1'b0;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            default: begin
                writes_rd = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller for a 5-stage RV32 pipeline.
// Tracks shadow copies of the execute, access and writeback instructions and
// produces stall/flush/freeze controls plus execute operand forwarding selects.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inst_de      in 32  instruction currently in decode
//   pc_sel       in  1  execute-stage redirect
//   dmem_ready   in  1  data memory completes its access this cycle
//   stall_fe     out 1  hold PC and fetch/decode register
//   stall_de     out 1  hold decode/execute register
//   flush_fe     out 1  load NOP into fetch/decode register
//   flush_de     out 1  load NOP into decode/execute register
//   freeze       out 1  hold every pipeline register
//   fwd_a/fwd_b  out 2  execute operand source (00 regfile, 01 access, 10 writeback)
// Build option: define HAZARD_FWD_EN to enable forwarding; otherwise every
// register dependency on an in-flight producer stalls decode until it retires.
module hazard_ctl
    import rv32_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_de,
    input  logic        pc_sel,
    input  logic        dmem_ready,
    output logic        stall_fe,
    output logic        stall_de,
    output logic        flush_fe,
    output logic        flush_de,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    logic [31:0] ex_q;
    logic [31:0] acc_q;
    logic [31:0] wb_q;
    logic        flush_pend_r;
    ctl_state_e  state_r;
    ctl_state_e  state_nxt_s;

    dec_t de_s;
    dec_t ex_s;
    dec_t acc_s;
    dec_t wb_s;
    logic dec_unused_s;

    logic mem_busy_s;
    logic redirect_s;
    logic data_haz_s;
    logic load_use_s;

    hazard_dec u_dec_de (.inst(inst_de), .rd(de_s.rd), .rs1(de_s.rs1), .rs2(de_s.rs2),
                         .writes_rd(de_s.writes_rd), .uses_rs1(de_s.uses_rs1),
                         .uses_rs2(de_s.uses_rs2), .is_load(de_s.is_load), .is_mem(de_s.is_mem));
    hazard_dec u_dec_ex (.inst(ex_q), .rd(ex_s.rd), .rs1(ex_s.rs1), .rs2(ex_s.rs2),
                         .writes_rd(ex_s.writes_rd), .uses_rs1(ex_s.uses_rs1),
                         .uses_rs2(ex_s.uses_rs2), .is_load(ex_s.is_load), .is_mem(ex_s.is_mem));
    hazard_dec u_dec_acc (.inst(acc_q), .rd(acc_s.rd), .rs1(acc_s.rs1), .rs2(acc_s.rs2),
                          .writes_rd(acc_s.writes_rd), .uses_rs1(acc_s.uses_rs1),
                          .uses_rs2(acc_s.uses_rs2), .is_load(acc_s.is_load), .is_mem(acc_s.is_mem));
    hazard_dec u_dec_wb (.inst(wb_q), .rd(wb_s.rd), .rs1(wb_s.rs1), .rs2(wb_s.rs2),
                         .writes_rd(wb_s.writes_rd), .uses_rs1(wb_s.uses_rs1),
                         .uses_rs2(wb_s.uses_rs2), .is_load(wb_s.is_load), .is_mem(wb_s.is_mem));

    // Not every decoded field is needed in every stage.
    assign dec_unused_s = ^{de_s, ex_s, acc_s, wb_s};

    assign mem_busy_s = acc_s.is_mem & ~dmem_ready;
    // A redirect seen while frozen is remembered and applied once the pipe moves.
    assign redirect_s = ~mem_busy_s & (pc_sel | flush_pend_r);

`ifdef HAZARD_FWD_EN
    assign data_haz_s = ex_s.is_load &
                        (reg_match(de_s.uses_rs1, de_s.rs1, ex_s.writes_rd, ex_s.rd) |
                         reg_match(de_s.uses_rs2, de_s.rs2, ex_s.writes_rd, ex_s.rd));
    assign fwd_a = fwd_sel(ex_s.uses_rs1, ex_s.rs1, acc_s, wb_s);
    assign fwd_b = fwd_sel(ex_s.uses_rs2, ex_s.rs2, acc_s, wb_s);
`else
    // Without bypass paths, decode waits until the producer has left writeback.
    assign data_haz_s = reg_match(de_s.uses_rs1, de_s.rs1, ex_s.writes_rd,  ex_s.rd)  |
                        reg_match(de_s.uses_rs2, de_s.rs2, ex_s.writes_rd,  ex_s.rd)  |
                        reg_match(de_s.uses_rs1, de_s.rs1, acc_s.writes_rd, acc_s.rd) |
                        reg_match(de_s.uses_rs2, de_s.rs2, acc_s.writes_rd, acc_s.rd) |
                        reg_match(de_s.uses_rs1, de_s.rs1, wb_s.writes_rd,  wb_s.rd)  |
                        reg_match(de_s.uses_rs2, de_s.rs2, wb_s.writes_rd,  wb_s.rd);
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    assign load_use_s = ~mem_busy_s & ~redirect_s & data_haz_s;

    // Next-state and control outputs: freeze > redirect flush > data-hazard stall.
    always_comb begin
        state_nxt_s = state_r;
        stall_fe    = 1'b0;
        stall_de    = 1'b0;
        flush_fe    = 1'b0;
        flush_de    = 1'b0;
        freeze      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_busy_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
        if (rst) begin
            freeze = 1'b0;
        end else if (mem_busy_s) begin
            freeze   = 1'b1;
            stall_fe = 1'b1;
            stall_de = 1'b1;
        end else if (redirect_s) begin
            flush_fe = 1'b1;
            flush_de = 1'b1;
        end else if (load_use_s) begin
            stall_fe = 1'b1;
            stall_de = 1'b1;
            flush_de = 1'b1;
        end else begin
            freeze = 1'b0;
        end
    end

    // Shadow pipeline, pending-redirect flag and FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= NOP_INST;
            acc_q        <= NOP_INST;
            wb_q         <= NOP_INST;
            flush_pend_r <= 1'b0;
            state_r      <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
            if (mem_busy_s) begin
                flush_pend_r <= flush_pend_r | pc_sel;
            end else begin
                wb_q         <= acc_q;
                acc_q        <= ex_q;
                ex_q         <= (redirect_s | load_use_s) ? NOP_INST : inst_de;
                flush_pend_r <= 1'b0;
            end
        end
    end

endmodule
